// File: rtl/txe_read_pkg.sv
// Shared ethernet definitions for the transmit reader: widths, FSM states and byte-lane order.
package txe_read_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned ETH_MIN_PAYLOAD = 60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } txe_state_e;

    // MSB-first lane order, identical to the receive writer.
    function automatic logic [BYTE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane);
        logic [BYTE_W-1:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/txe_wordbuf.sv
// Word plus prefetch double buffer for the transmit reader; exposes the next word so the
// byte output can be registered without a bubble.
module txe_wordbuf
    import txe_read_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_fill,
    input  logic              i_adv,
    input  logic [WORD_W-1:0] i_data,
    output logic [WORD_W-1:0] o_word_nxt_c,
    output logic              o_pf_vld
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] pf_q, pf_d;
    logic              pf_vld_q, pf_vld_d;

    always_comb begin
        word_d   = word_q;
        pf_d     = pf_q;
        pf_vld_d = pf_vld_q;
        if (i_load) begin
            word_d   = i_data;
            pf_vld_d = 1'b0;
        end else if (i_adv) begin
            word_d   = pf_q;
            pf_vld_d = 1'b0;
        end
        if (i_fill) begin
            pf_d     = i_data;
            pf_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            word_q   <= '0;
            pf_q     <= '0;
            pf_vld_q <= 1'b0;
        end else begin
            word_q   <= word_d;
            pf_q     <= pf_d;
            pf_vld_q <= pf_vld_d;
        end
    end

    assign o_word_nxt_c = word_d;
    assign o_pf_vld     = pf_vld_q;

endmodule

// File: rtl/txe_read.sv
// Transmit packet reader: fetches buffer words and streams bytes MSB-first with a one-word
// prefetch. Define TXEREAD_PAD_EN to zero-pad short packets to the minimum payload length.
module txe_read
    import txe_read_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd,
    input  logic [AW+1:0]     i_len,
    output logic              o_busy,
    output logic              o_rd,
    output logic [AW-1:0]     o_raddr,
    input  logic [WORD_W-1:0] i_rdata,
    output logic              o_v,
    output logic [BYTE_W-1:0] o_d,
    input  logic              i_ready,
    output logic              o_done
);

    localparam int unsigned LW = AW + 2;

    txe_state_e        state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     len_q, len_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              rd_q, rd_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic              v_q, v_d;
    logic [BYTE_W-1:0] d_q, d_d;
    logic              done_q, done_d;

    logic [LW-1:0]     plen;
    logic              load, fill, adv, accept, last;
    logic [AW:0]       nxt_idx;
    logic [AW+2:0]     nxt_end;
    logic [WORD_W-1:0] word_nxt;
    logic              pf_vld;
    logic [BYTE_W-1:0] byte_nxt;

`ifdef TXEREAD_PAD_EN
    assign plen = (len_q < LW'(ETH_MIN_PAYLOAD)) ? LW'(ETH_MIN_PAYLOAD) : len_q;
`else
    assign plen = len_q;
`endif

    assign accept = v_q && i_ready;
    assign last   = (cnt_q == plen - LW'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        pend_d   = rd_q;
        rd_d     = 1'b0;
        raddr_d  = raddr_q;
        done_d   = 1'b0;
        load     = 1'b0;
        fill     = 1'b0;
        adv      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd && (i_len != '0)) begin
                    state_d = ST_FIRST;
                    len_d   = i_len;
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                    raddr_d = '0;
                end
            end
            ST_FIRST: begin
                if (pend_q) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                fill = pend_q;
                if (accept) begin
                    if (last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                        adv   = (cnt_q[1:0] == 2'd3) && pf_vld;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Prefetch the following word whenever a new word becomes current.
        nxt_idx = {1'b0, cnt_d[LW-1:2]} + (AW+1)'(1);
        nxt_end = {nxt_idx, 2'b00};
        if ((load || adv) && (nxt_end < (AW+3)'(len_d))) begin
            rd_d    = 1'b1;
            raddr_d = nxt_idx[AW-1:0];
        end

        byte_nxt = lane_sel(word_nxt, cnt_d[1:0]);
`ifdef TXEREAD_PAD_EN
        if (cnt_d >= len_d) begin
            byte_nxt = '0;
        end
`endif
        v_d    = (state_d == ST_SEND);
        d_d    = v_d ? byte_nxt : '0;
        busy_d = (state_d == ST_FIRST) || (state_d == ST_SEND);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            raddr_q <= '0;
            v_q     <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            raddr_q <= raddr_d;
            v_q     <= v_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    txe_wordbuf u_wordbuf (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (load),
        .i_fill       (fill),
        .i_adv        (adv),
        .i_data       (i_rdata),
        .o_word_nxt_c (word_nxt),
        .o_pf_vld     (pf_vld)
    );

    assign o_busy  = busy_q;
    assign o_rd    = rd_q;
    assign o_raddr = raddr_q;
    assign o_v     = v_q;
    assign o_d     = d_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_txe_read.sv
// Self-checking bench for txe_read: byte-stream reference model over a word memory,
// randomized backpressure, reset and ignored-command scenarios.
module tb_txe_read;

    localparam int unsigned AW = 12;
    localparam int unsigned LW = AW + 2;

    logic          clk = 1'b0;
    logic          i_reset, i_cmd, i_ready;
    logic [LW-1:0] i_len;
    logic          o_busy, o_rd, o_v, o_done;
    logic [AW-1:0] o_raddr;
    logic [31:0]   i_rdata;
    logic [7:0]    o_d;

    logic [31:0]   mem [0:(1<<AW)-1];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    txe_read #(.AW(AW)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_cmd   (i_cmd),
        .i_len   (i_len),
        .o_busy  (o_busy),
        .o_rd    (o_rd),
        .o_raddr (o_raddr),
        .i_rdata (i_rdata),
        .o_v     (o_v),
        .o_d     (o_d),
        .i_ready (i_ready),
        .o_done  (o_done)
    );

    // Buffer: data one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (o_rd) i_rdata <= mem[o_raddr];
        else      i_rdata <= $urandom;
    end

    function automatic int padded(input int len);
`ifdef TXEREAD_PAD_EN
        return (len < 60) ? 60 : len;
`else
        return len;
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input int len);
        logic [31:0] w;
        if (k >= len) return 8'h00;
        w = mem[k / 4];
        return 8'(w >> (24 - 8 * (k % 4)));
    endfunction

    task automatic fill_mem(input int words);
        for (int i = 0; i < words; i++) mem[i] = $urandom;
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (o_busy !== 1'b0 || o_rd !== 1'b0 || o_raddr !== '0 || o_v !== 1'b0 ||
            o_d !== 8'h00 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b rd=%b raddr=%h v=%b d=%h done=%b, required all zero",
                     name, o_busy, o_rd, o_raddr, o_v, o_d, o_done);
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready pattern 1,0,0,1.
    // extra_at: cycle of an extra command to be ignored; reset_at: cycle to assert reset.
    task automatic run_pkt(input int len, input int mode, input int extra_at, input int reset_at);
        int         plen, idx, nrd, first_v, done_cyc;
        bit         stall_prev, rdy;
        logic [7:0] d_prev;
        plen = padded(len);
        idx = 0; nrd = 0; first_v = -1; done_cyc = -1; stall_prev = 0; d_prev = 8'h00;
        @(negedge clk);
        i_cmd = 1'b1; i_len = LW'(len); i_ready = 1'b1;
        for (int cyc = 1; cyc < 4 * plen + 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            i_cmd = (cyc == extra_at);
            i_len = LW'($urandom);
            if (reset_at >= 0 && cyc == reset_at + 1) begin
                check_idle_outputs("reset_mid_packet");
                i_reset = 1'b0;
                i_ready = 1'b1;
                return;
            end
            n_checks++;
            if (o_busy !== (idx < plen)) begin
                n_fail++;
                $display("FAIL busy len=%0d cyc=%0d: got %b, required %b", len, cyc, o_busy, idx < plen);
            end
            n_checks++;
            if (o_done !== (idx == plen)) begin
                n_fail++;
                $display("FAIL done len=%0d cyc=%0d: got %b, required %b", len, cyc, o_done, idx == plen);
            end
            if (idx == plen) begin
                done_cyc = cyc;
                n_checks++;
                if (o_v !== 1'b0) begin
                    n_fail++;
                    $display("FAIL v_after_last len=%0d: got %b, required 0", len, o_v);
                end
            end
            if (o_rd === 1'b1) begin
                n_checks++;
                if (o_raddr !== AW'(nrd)) begin
                    n_fail++;
                    $display("FAIL raddr len=%0d read %0d: got %0d, required %0d", len, nrd, o_raddr, nrd);
                end
                nrd++;
            end
            if (stall_prev) begin
                n_checks++;
                if (o_v !== 1'b1 || o_d !== d_prev) begin
                    n_fail++;
                    $display("FAIL stall_hold len=%0d cyc=%0d: v=%b d=%h, required v=1 d=%h",
                             len, cyc, o_v, o_d, d_prev);
                end
            end
            if (o_v === 1'b1 && first_v < 0) first_v = cyc;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
            endcase
            if (reset_at == cyc) i_reset = 1'b1;
            i_ready = rdy;
            if (o_v === 1'b1 && rdy && idx < plen) begin
                n_checks++;
                if (o_d !== exp_byte(idx, len)) begin
                    n_fail++;
                    $display("FAIL byte len=%0d idx=%0d: got %h, required %h", len, idx, o_d, exp_byte(idx, len));
                end
                idx++;
            end
            stall_prev = (o_v === 1'b1) && !rdy;
            d_prev     = o_d;
        end
        i_cmd = 1'b0; i_ready = 1'b1;
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL timeout len=%0d: accepted %0d bytes, required %0d", len, idx, plen);
            return;
        end
        n_checks++;
        if (nrd != (len + 3) / 4) begin
            n_fail++;
            $display("FAIL read_count len=%0d: got %0d, required %0d", len, nrd, (len + 3) / 4);
        end
        if (mode == 0) begin
            n_checks++;
            if (first_v != 3 || done_cyc != plen + 3) begin
                n_fail++;
                $display("FAIL latency len=%0d: first_v=%0d done=%0d, required 3 and %0d",
                         len, first_v, done_cyc, plen + 3);
            end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_cmd = 1'b0; i_len = '0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        i_reset = 1'b0;
    endtask

    task automatic test_basic;
        mem[0] = 32'h11223344; mem[1] = 32'h55667788; mem[2] = 32'hCAFEF00D;
        run_pkt(8, 0, -1, -1);
    endtask

    task automatic test_short;
        mem[0] = 32'h01020304; mem[1] = 32'hAABBCCDD; mem[2] = 32'h99999999;
        run_pkt(5, 0, -1, -1);
    endtask

    task automatic test_stall;
        fill_mem(4);
        run_pkt(8, 2, -1, -1);
    endtask

    task automatic test_zero_len;
        @(negedge clk);
        i_cmd = 1'b1; i_len = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            i_cmd = 1'b0;
            n_checks++;
            if (o_rd !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_v !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len cyc=%0d: rd=%b busy=%b done=%b v=%b, required all 0",
                         c, o_rd, o_busy, o_done, o_v);
            end
        end
    endtask

    task automatic test_cmd_while_busy;
        fill_mem(8);
        run_pkt(13, 0, 5, -1);
    endtask

    task automatic test_reset_mid;
        fill_mem(4);
        run_pkt(8, 0, -1, 6);
        mem[0] = 32'hDEC0ADDE;
        run_pkt(4, 0, -1, -1);
    endtask

    task automatic test_back_to_back;
        fill_mem(4);
        run_pkt(3, 0, -1, -1);
        run_pkt(6, 0, -1, -1);
    endtask

    task automatic test_random;
        for (int p = 0; p < 8; p++) begin
            fill_mem(32);
            run_pkt(int'($urandom_range(1, 90)), int'($urandom_range(0, 1)), -1, -1);
        end
    endtask

    task automatic test_max_len;
        fill_mem(1 << AW);
        run_pkt((1 << LW) - 1, 0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_stall();
        test_zero_len();
        test_cmd_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_max_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
